// File: rtl/socetlib_mc_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : socetlib_mc_fifo_pkg
// Description : Shared types and sizing helpers for the multi-channel FIFO.
//               socetlib_fifo_status_t bundles the per-channel status. Its
//               count field has a fixed width, so one struct type serves
//               every DEPTH. Each instance uses only the low cnt_w(DEPTH)
//               bits of that field.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package socetlib_mc_fifo_pkg;

  localparam int c_status_cnt_w = 16;

  // Width needed to hold an occupancy of 0..depth.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Width of a pointer into one channel (0..depth-1).
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width of a channel select; at least one bit even when nch == 1.
  function automatic int sel_w(input int nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  typedef struct packed {
    logic                      full;
    logic                      empty;
    logic                      almost_full;
    logic                      almost_empty;
    logic                      overrun;
    logic                      underrun;
    logic [c_status_cnt_w-1:0] count;
  } socetlib_fifo_status_t;

endpackage
`default_nettype wire

// File: rtl/socetlib_mc_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : socetlib_mc_fifo_ctrl
// Description : Bookkeeping for one FIFO channel. This module holds the write
//               and read pointers, the occupancy count and the sticky error
//               flags. It decides whether the requested push and pop are
//               accepted. The storage itself lives in the parent.
// Ports       : clk_i, rst_i        clock, synchronous active-high reset
//               push_i, pop_i       write / read requested on this channel
//               clear_i             flush this channel (overrides push/pop)
//               push_ok_o, pop_ok_o accepted push / pop this cycle
//               wptr_o, rptr_o      current write / read slot
//               status_o            flags and occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module socetlib_mc_fifo_ctrl
  import socetlib_mc_fifo_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      push_i,
  input  logic                      pop_i,
  input  logic                      clear_i,
  output logic                      push_ok_o,
  output logic                      pop_ok_o,
  output logic [ptr_w(DEPTH)-1:0]   wptr_o,
  output logic [ptr_w(DEPTH)-1:0]   rptr_o,
  output socetlib_fifo_status_t     status_o
);

  localparam int              c_pw     = ptr_w(DEPTH);
  localparam int              c_cw     = cnt_w(DEPTH);
  localparam logic [c_pw-1:0] c_last   = c_pw'(DEPTH - 1);
  localparam logic [c_cw-1:0] c_depth  = c_cw'(DEPTH);
  localparam logic [c_cw-1:0] c_afull  = c_cw'(AFULL_TH);
  localparam logic [c_cw-1:0] c_aempty = c_cw'(AEMPTY_TH);

  logic [c_pw-1:0] wptr_q, wptr_d;
  logic [c_pw-1:0] rptr_q, rptr_d;
  logic [c_cw-1:0] count_q, count_d;
  logic            overrun_q, overrun_d;
  logic            underrun_q, underrun_d;

  logic            w_full;
  logic            w_empty;
  logic            w_push_ok;
  logic            w_pop_ok;

  function automatic logic [c_pw-1:0] f_next(input logic [c_pw-1:0] p);
    return (p == c_last) ? '0 : p + 1'b1;
  endfunction

  assign w_full   = (count_q == c_depth);
  assign w_empty  = (count_q == '0);
  assign w_pop_ok = pop_i & ~clear_i & ~w_empty;
  // A full channel still takes a write when the same cycle pops it: the
  // popped slot is the one being overwritten.
  assign w_push_ok = push_i & ~clear_i & (~w_full | w_pop_ok);

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    overrun_d  = overrun_q;
    underrun_d = underrun_q;
    if (clear_i) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      overrun_d  = 1'b0;
      underrun_d = 1'b0;
    end else begin
      if (w_push_ok) wptr_d = f_next(wptr_q);
      if (w_pop_ok)  rptr_d = f_next(rptr_q);
      case ({w_push_ok, w_pop_ok})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
      if (push_i && !w_push_ok) overrun_d  = 1'b1;
      if (pop_i && w_empty)     underrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      overrun_q  <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      overrun_q  <= overrun_d;
      underrun_q <= underrun_d;
    end
  end

  assign push_ok_o             = w_push_ok;
  assign pop_ok_o              = w_pop_ok;
  assign wptr_o                = wptr_q;
  assign rptr_o                = rptr_q;
  assign status_o.full         = w_full;
  assign status_o.empty        = w_empty;
  assign status_o.almost_full  = (count_q >= c_afull);
  assign status_o.almost_empty = (count_q <= c_aempty);
  assign status_o.overrun      = overrun_q;
  assign status_o.underrun     = underrun_q;
  assign status_o.count        = c_status_cnt_w'(count_q);

endmodule
`default_nettype wire

// File: rtl/socetlib_mc_fifo.sv
`default_nettype none
// ============================================================================
// Module      : socetlib_mc_fifo
// Description : NCH independent circular FIFOs of DEPTH words each. They
//               share one storage array, one write port and one registered
//               read port. Each port picks its channel every cycle.
// Ports       : CLK, RST              clock, synchronous active-high reset
//               WEN, wsel, wdata      write request, channel, data
//               REN, rsel             read request, channel
//               clear                 per-channel flush
//               rdata, rvalid         registered read data / valid strobe
//               full, empty, almost_full, almost_empty  per-channel status
//               count                 per-channel occupancy, ch0 in LSBs
//               overrun, underrun     sticky per-channel error flags
// Revision    : 1.0 - initial release
// ============================================================================
module socetlib_mc_fifo
  import socetlib_mc_fifo_pkg::*;
#(
  parameter int WIDTH     = 16,
  parameter int DEPTH     = 8,
  parameter int NCH       = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic                          WEN,
  input  logic [sel_w(NCH)-1:0]         wsel,
  input  logic [WIDTH-1:0]              wdata,
  input  logic                          REN,
  input  logic [sel_w(NCH)-1:0]         rsel,
  input  logic [NCH-1:0]                clear,
  output logic [WIDTH-1:0]              rdata,
  output logic                          rvalid,
  output logic [NCH-1:0]                full,
  output logic [NCH-1:0]                empty,
  output logic [NCH-1:0]                almost_full,
  output logic [NCH-1:0]                almost_empty,
  output logic [NCH*cnt_w(DEPTH)-1:0]   count,
  output logic [NCH-1:0]                overrun,
  output logic [NCH-1:0]                underrun
);

  localparam int c_sw = sel_w(NCH);
  localparam int c_pw = ptr_w(DEPTH);
  localparam int c_cw = cnt_w(DEPTH);
  localparam int c_iw = $clog2(NCH * DEPTH);

  logic [WIDTH-1:0]                mem_q [NCH*DEPTH];
  logic [WIDTH-1:0]                rdata_q;
  logic                            rvalid_q;

  logic [NCH-1:0]                  w_push_ok;
  logic [NCH-1:0]                  w_pop_ok;
  logic [c_pw-1:0]                 w_wptr [NCH];
  logic [c_pw-1:0]                 w_rptr [NCH];
  socetlib_fifo_status_t           w_status [NCH];
  logic [NCH*c_status_cnt_w-1:0]   w_cnt_unused;
  logic [c_iw-1:0]                 w_widx;
  logic [c_iw-1:0]                 w_ridx;

  // An out-of-range select matches no channel, so the request is ignored.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
    socetlib_mc_fifo_ctrl #(
      .DEPTH     (DEPTH),
      .AFULL_TH  (AFULL_TH),
      .AEMPTY_TH (AEMPTY_TH)
    ) u_ctrl (
      .clk_i     (CLK),
      .rst_i     (RST),
      .push_i    (WEN && (wsel == c_sw'(gi))),
      .pop_i     (REN && (rsel == c_sw'(gi))),
      .clear_i   (clear[gi]),
      .push_ok_o (w_push_ok[gi]),
      .pop_ok_o  (w_pop_ok[gi]),
      .wptr_o    (w_wptr[gi]),
      .rptr_o    (w_rptr[gi]),
      .status_o  (w_status[gi])
    );

    assign full[gi]                            = w_status[gi].full;
    assign empty[gi]                           = w_status[gi].empty;
    assign almost_full[gi]                     = w_status[gi].almost_full;
    assign almost_empty[gi]                    = w_status[gi].almost_empty;
    assign overrun[gi]                         = w_status[gi].overrun;
    assign underrun[gi]                        = w_status[gi].underrun;
    assign count[gi*c_cw +: c_cw]              = w_status[gi].count[c_cw-1:0];
    assign w_cnt_unused[gi*c_status_cnt_w +: c_status_cnt_w] = w_status[gi].count;
  end

  // Flat storage address = channel * DEPTH + pointer. At most one channel
  // accepts a push (or a pop) per cycle, so the OR-style scan selects it.
  always_comb begin
    w_widx = '0;
    w_ridx = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      if (w_push_ok[ch]) w_widx = c_iw'(ch * DEPTH) + c_iw'(w_wptr[ch]);
      if (w_pop_ok[ch])  w_ridx = c_iw'(ch * DEPTH) + c_iw'(w_rptr[ch]);
    end
  end

  // Storage is not reset. A push and a pop on the same full channel hit the
  // same slot, and the read sees the old word.
  always_ff @(posedge CLK) begin
    if (|w_push_ok) mem_q[w_widx] <= wdata;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= |w_pop_ok;
      if (|w_pop_ok) rdata_q <= mem_q[w_ridx];
    end
  end

  assign rdata  = rdata_q;
  assign rvalid = rvalid_q;

endmodule
`default_nettype wire
